// File: rtl/lut_neuron_sequencer.sv
// Time-multiplexed LogicNets sparse layer: a shared truth-table memory plus a connectivity
// table evaluate N_NEURONS LUT neurons one per cycle; result leaves over valid/ready.
module lut_neuron_sequencer #(
  parameter int IN_BITS   = 64,
  parameter int N_NEURONS = 16,
  parameter int FANIN     = 8,
  parameter int IDXW      = $clog2(IN_BITS),
  parameter int CFG_AW    = $clog2(N_NEURONS) + FANIN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_BITS-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_NEURONS-1:0] out_data,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [CFG_AW-1:0]    cfg_addr,
  input  logic [IDXW-1:0]      cfg_wdata,
  output logic                 busy
);
  localparam int NW       = $clog2(N_NEURONS);
  localparam int TT_DEPTH = N_NEURONS << FANIN;
  localparam int CN_DEPTH = N_NEURONS * FANIN;
  localparam int CNW      = $clog2(CN_DEPTH);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
  state_t state, state_nx;

  logic              tt_mem   [TT_DEPTH];
  logic [IDXW-1:0]   conn_mem [CN_DEPTH];
  logic [IN_BITS-1:0] in_reg;
  logic [NW-1:0]     n;
  logic              drain;
  logic              issue;
  logic              accept;
  logic              cfg_ok;
  logic [FANIN-1:0]  pattern;
  logic              rd_bit;
  logic              rd_vld;
  logic [NW-1:0]     rd_idx;

  // Connectivity codes past the last input select a constant 0.
  function automatic logic sel_bit(input logic [IN_BITS-1:0] v, input logic [IDXW-1:0] idx);
    return (int'(idx) < IN_BITS) ? v[idx] : 1'b0;
  endfunction

  assign accept = in_valid && in_ready;
  assign issue  = (state == EVAL) && !drain;

  always_comb begin
    cfg_ok = 1'b0;
    if (cfg_we && state == IDLE) begin
      if (cfg_sel) cfg_ok = int'(cfg_addr) < CN_DEPTH;
      else         cfg_ok = int'(cfg_addr) < TT_DEPTH;
    end
  end

  always_comb begin
    pattern = '0;
    for (int k = 0; k < FANIN; k++)
      pattern[k] = sel_bit(in_reg, conn_mem[CNW'(int'(n) * FANIN + k)]);
  end

  // NOTE: the tables are plain storage with no reset branch, so they map onto RAM and
  // survive rst; only control state is reset below.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      if (cfg_sel) conn_mem[CNW'(cfg_addr)] <= cfg_wdata;
      else         tt_mem[cfg_addr]         <= cfg_wdata[0];
    end
    if (issue) rd_bit <= tt_mem[{n, pattern}];
  end

  // NOTE: every output and next-state term gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = !cfg_we;
        if (in_valid && !cfg_we) state_nx = EVAL;
      end
      EVAL: if (drain) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so each register samples values from before
  // the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_reg   <= '0;
      n        <= '0;
      drain    <= 1'b0;
      rd_vld   <= 1'b0;
      rd_idx   <= '0;
      out_data <= '0;
    end else begin
      state  <= state_nx;
      rd_vld <= issue;
      rd_idx <= n;
      if (accept) begin
        in_reg   <= in_data;
        out_data <= '0;
        n        <= '0;
        drain    <= 1'b0;
      end
      // drain marks the extra cycle that retires the last neuron's read
      if (issue) begin
        n <= n + 1'b1;
        if (n == NW'(N_NEURONS - 1)) drain <= 1'b1;
      end
      if (rd_vld) out_data[rd_idx] <= rd_bit;
    end
  end

endmodule

// File: tb/tb_lut_neuron_sequencer.sv
// Randomized bench for lut_neuron_sequencer against a table-lookup model of the layer.
module tb_lut_neuron_sequencer;
  // 56 inputs with 6-bit indices leave codes 56..63 free to exercise out-of-range connectivity.
  localparam int IN_BITS = 56;
  localparam int N       = 16;
  localparam int FANIN   = 8;
  localparam int IDXW    = $clog2(IN_BITS);
  localparam int AW      = $clog2(N) + FANIN;
  localparam int LAT     = N + 2;
  localparam int PATS    = 1 << FANIN;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic               cfg_we = 1'b0;
  logic               cfg_sel = 1'b0;
  logic [IN_BITS-1:0] in_data = '0;
  logic [AW-1:0]      cfg_addr = '0;
  logic [IDXW-1:0]    cfg_wdata = '0;
  logic               in_ready, out_valid, busy;
  logic [N-1:0]       out_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic tt_m   [N][PATS];
  int   conn_m [N][FANIN];

  lut_neuron_sequencer #(.IN_BITS(IN_BITS), .N_NEURONS(N), .FANIN(FANIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pattern_of(input int j, input logic [IN_BITS-1:0] v);
    int a = 0;
    for (int k = 0; k < FANIN; k++)
      if (conn_m[j][k] < IN_BITS && v[conn_m[j][k]]) a |= (1 << k);
    return a;
  endfunction

  function automatic logic [N-1:0] model_out(input logic [IN_BITS-1:0] v);
    logic [N-1:0] r;
    for (int j = 0; j < N; j++) r[j] = tt_m[j][pattern_of(j, v)];
    return r;
  endfunction

  function automatic logic [IN_BITS-1:0] rand_vec();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[IN_BITS-1:0];
  endfunction

  task automatic cfg_write(input logic sel, input int addr, input int data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = AW'(addr); cfg_wdata = IDXW'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic set_tt(input int j, input int a, input logic b);
    tt_m[j][a] = b;
    cfg_write(1'b0, j * PATS + a, int'(b));
  endtask

  task automatic set_conn(input int j, input int k, input int idx);
    conn_m[j][k] = idx;
    cfg_write(1'b1, j * FANIN + k, idx);
  endtask

  task automatic start_vec(input logic [IN_BITS-1:0] v);
    int g = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = v;
    while (!in_ready && g < 40) begin @(negedge clk); g++; end
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_out(input string tag);
    while (!out_valid && (cyc - acc_cyc) < 60) begin @(posedge clk); #1; end
    check(tag, cyc - acc_cyc + 1, LAT);
  endtask

  task automatic finish_out();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic run_vec(input logic [IN_BITS-1:0] v, input string tag);
    start_vec(v);
    wait_out("latency");
    check(tag, out_data, model_out(v));
    finish_out();
  endtask

  initial begin
    logic [IN_BITS-1:0] v;
    logic [7:0]         n0_pat [5];
    logic               n0_exp [5];
    int                 a;
    logic [N-1:0]       hold_exp;

    n0_pat = '{8'h21, 8'h00, 8'hFF, 8'h28, 8'h20};
    n0_exp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk); rst = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);

    for (int j = 0; j < N; j++)
      for (int p = 0; p < PATS; p++) set_tt(j, p, 1'($urandom_range(0, 1)));
    for (int j = 0; j < N; j++)
      for (int k = 0; k < FANIN; k++) set_conn(j, k, int'($urandom_range(0, 63)));
    // a connectivity address one past the end must not alias entry 0
    cfg_write(1'b1, N * FANIN, (conn_m[0][0] + 1) % 64);

    // reset during evaluation aborts and clears the partial result
    start_vec(rand_vec());
    repeat (5) @(posedge clk);
    #1 check("mid_eval_busy", busy, 1);
    @(negedge clk); rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_out_data", out_data, 0);
    @(negedge clk); rst = 1'b0;
    #1 check("abort_in_ready", in_ready, 1);
    repeat (20) @(posedge clk);
    #1 check("abort_no_out_valid", out_valid, 0);

    // neuron 0 wired to inputs 0..7 with f(A) = A5&A0 | A5&A3&!A1
    for (int k = 0; k < FANIN; k++) set_conn(0, k, k);
    for (int p = 0; p < PATS; p++) begin
      logic [7:0] pa;
      pa = 8'(p);
      set_tt(0, p, (pa[5] & pa[0]) | (pa[5] & pa[3] & ~pa[1]));
    end
    for (int i = 0; i < 5; i++) begin
      v = rand_vec();
      v[7:0] = n0_pat[i];
      start_vec(v);
      wait_out("n0_latency");
      check("n0_vector", out_data, model_out(v));
      check("n0_bit", out_data[0], n0_exp[i]);
      finish_out();
    end

    for (int i = 0; i < 200; i++) run_vec(rand_vec(), "random_vector");

    // backpressure: result held, input ignored, then back to idle
    v = rand_vec();
    hold_exp = model_out(v);
    start_vec(v);
    wait_out("bp_latency");
    @(negedge clk); in_valid = 1'b1; in_data = ~v;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_data", out_data, hold_exp);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("bp_release_busy", busy, 0);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);

    // config write and input offered together: write wins, vector taken next cycle
    v = rand_vec();
    a = pattern_of(3, v);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = AW'(3 * PATS + a);
    cfg_wdata = '0; cfg_wdata[0] = ~tt_m[3][a];
    in_valid = 1'b1; in_data = v;
    #1 check("collide_in_ready", in_ready, 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    tt_m[3][a] = ~tt_m[3][a];
    check("collide_not_accepted", busy, 0);
    @(negedge clk);
    check("collide_in_ready_next", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
    wait_out("collide_latency");
    check("collide_vector", out_data, model_out(v));
    check("collide_bit3", out_data[3], tt_m[3][a]);
    finish_out();

    // config writes during evaluation are dropped
    v = rand_vec();
    a = pattern_of(N - 1, v);
    start_vec(v);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = AW'((N - 1) * PATS + a);
    cfg_wdata = '0; cfg_wdata[0] = ~tt_m[N-1][a];
    @(negedge clk);
    cfg_sel = 1'b1; cfg_addr = AW'((N - 1) * FANIN);
    cfg_wdata = IDXW'((conn_m[N-1][0] + 1) % 64);
    @(negedge clk); cfg_we = 1'b0;
    wait_out("evalcfg_latency");
    check("evalcfg_vector", out_data, model_out(v));
    finish_out();
    run_vec(v, "evalcfg_after");

    // out-of-range index reads 0 even with every input high; last neuron lands in MSB
    for (int k = 0; k < FANIN; k++) set_conn(N - 1, k, k + 8);
    set_conn(N - 1, 2, IN_BITS);
    for (int p = 0; p < PATS; p++) set_tt(N - 1, p, p == 8'hFB);
    v = '1;
    start_vec(v);
    wait_out("oor_latency");
    check("oor_vector", out_data, model_out(v));
    check("oor_msb", out_data[N-1], 1);
    finish_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
